// File: rtl/hyper_axi_mem_bridge_pkg.sv
// hyper_axi_mem_pkg: FSM states, register map offsets and AXI burst/response codes
package hyper_axi_mem_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_e;
   localparam logic [7:0] RegIdOff = 8'h00;
   localparam logic [7:0] RegPhysInUseOff = 8'h20;
   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr = 2'b01;
   localparam logic [1:0] BurstWrap = 2'b10;
   localparam logic [1:0] RespOkay = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;
endpackage

// File: rtl/hyper_axi_mem_bridge_if.sv
// hyper_axi_mem_bridge_if: AXI4 aw/w/b/ar/r channel bundle with master and slave views
interface hyper_axi_mem_bridge_if #(
   parameter int AxiDataWidth = 64,
   parameter int AxiAddrWidth = 32,
   parameter int AxiIdWidth = 6,
   parameter int AxiUserWidth = 1
);
   logic [AxiIdWidth-1:0] aw_id;
   logic [AxiAddrWidth-1:0] aw_addr;
   logic [7:0] aw_len;
   logic [2:0] aw_size;
   logic [1:0] aw_burst;
   logic [AxiUserWidth-1:0] aw_user;
   logic aw_valid;
   logic aw_ready;
   logic [AxiDataWidth-1:0] w_data;
   logic [AxiDataWidth/8-1:0] w_strb;
   logic w_last;
   logic [AxiUserWidth-1:0] w_user;
   logic w_valid;
   logic w_ready;
   logic [AxiIdWidth-1:0] b_id;
   logic [1:0] b_resp;
   logic [AxiUserWidth-1:0] b_user;
   logic b_valid;
   logic b_ready;
   logic [AxiIdWidth-1:0] ar_id;
   logic [AxiAddrWidth-1:0] ar_addr;
   logic [7:0] ar_len;
   logic [2:0] ar_size;
   logic [1:0] ar_burst;
   logic [AxiUserWidth-1:0] ar_user;
   logic ar_valid;
   logic ar_ready;
   logic [AxiIdWidth-1:0] r_id;
   logic [AxiDataWidth-1:0] r_data;
   logic [1:0] r_resp;
   logic r_last;
   logic [AxiUserWidth-1:0] r_user;
   logic r_valid;
   logic r_ready;
   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
      input b_id, b_resp, b_user, b_valid, output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
      input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
   );
   modport slave (
      input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
      input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
      output b_id, b_resp, b_user, b_valid, input b_ready,
      input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
   );
endinterface

// File: rtl/hyper_axi_mem_bridge_bank.sv
// hyper_axi_mem_bank: single-port byte-enable RAM with registered read data held while idle
module hyper_axi_mem_bank #(
   parameter int DataWidth = 64,
   parameter int AddrWidth = 10
) (
   input  logic                   clk_i,
   input  logic                   en_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic [DataWidth-1:0]   rdata_o
);
   logic [DataWidth-1:0] mem_q [2**AddrWidth];
   logic [DataWidth-1:0] rdata_q;
   // Byte-lane write, or read into the output register; output holds when not enabled
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int i = 0; i < DataWidth/8; i++)
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end else if (en_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/hyper_axi_mem_bridge.sv
// hyper_axi_mem_bridge: AXI4 slave serving INCR bursts one at a time from banked RAM, plus a config register port.
// Define HYPER_AXI_OOR_SLVERR_EN to answer bursts starting outside the window with SLVERR instead of wrapping.
module hyper_axi_mem_bridge
   import hyper_axi_mem_pkg::*;
#(
   parameter int AxiDataWidth = 64,
   parameter int AxiAddrWidth = 32,
   parameter int AxiIdWidth = 6,
   parameter int AxiUserWidth = 1,
   parameter int RegAw = 8,
   parameter int RegDw = 32,
   parameter int NumPhys = 2,
   parameter int NumChips = 2,
   parameter logic [AxiAddrWidth-1:0] MemBase = 32'h8000_0000,
   parameter int unsigned MemBytes = 32'h40_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   hyper_axi_mem_bridge_if.slave axi_slv,
   input  logic [RegAw-1:0]     reg_addr_i,
   input  logic                 reg_write_i,
   input  logic [RegDw-1:0]     reg_wdata_i,
   input  logic [RegDw/8-1:0]   reg_wstrb_i,
   input  logic                 reg_valid_i,
   output logic [RegDw-1:0]     reg_rdata_o,
   output logic                 reg_error_o,
   output logic                 reg_ready_o
);
   localparam int Wb = $clog2(AxiDataWidth/8);
   localparam int OffW = $clog2(MemBytes);
   localparam int IdxW = OffW - Wb;

   state_e state_q, state_d;
   logic [AxiIdWidth-1:0] id_q, id_d;
   logic [AxiAddrWidth-1:0] addr_q, addr_d, addr_nxt, acc_addr, off_full;
   logic [7:0] len_q, len_d, beat_q, beat_d;
   logic [2:0] size_q, size_d;
   logic oor_q, oor_d, mode_q, bank_sel_q, phys_in_use_q;
   logic mode, two_bank, ram_en, ram_we, ram_bank, aw_oor, ar_oor, unused_ok;
   logic [OffW-1:0] off;
   logic [IdxW-1:0] ram_idx;
   logic [AxiDataWidth-1:0] bank_rdata [NumPhys];

`ifdef HYPER_AXI_OOR_SLVERR_EN
   assign aw_oor = (axi_slv.aw_addr - MemBase) >= AxiAddrWidth'(MemBytes);
   assign ar_oor = (axi_slv.ar_addr - MemBase) >= AxiAddrWidth'(MemBytes);
`else
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
`endif

   assign addr_nxt = addr_q + (AxiAddrWidth'(1) << size_q);
   assign mode = (state_q == ST_IDLE) ? phys_in_use_q : mode_q;
   assign two_bank = (NumPhys == 2) && mode;
   assign off_full = acc_addr - MemBase;
   assign off = off_full[OffW-1:0];
   assign ram_bank = two_bank && off[Wb];
   assign ram_idx = two_bank ? IdxW'(off[OffW-1:Wb+1]) : off[OffW-1:Wb];

   // Next-state, channel handshakes and RAM access control
   always_comb begin
      state_d = state_q;
      id_d = id_q;
      addr_d = addr_q;
      len_d = len_q;
      size_d = size_q;
      beat_d = beat_q;
      oor_d = oor_q;
      acc_addr = addr_q;
      ram_en = 1'b0;
      ram_we = 1'b0;
      axi_slv.aw_ready = 1'b0;
      axi_slv.ar_ready = 1'b0;
      axi_slv.w_ready = 1'b0;
      axi_slv.b_valid = 1'b0;
      axi_slv.r_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            axi_slv.aw_ready = ~rst_i;
            axi_slv.ar_ready = ~rst_i & ~axi_slv.aw_valid;
            if (axi_slv.aw_valid && !rst_i) begin
               state_d = ST_WRITE;
               id_d = axi_slv.aw_id;
               addr_d = axi_slv.aw_addr;
               len_d = axi_slv.aw_len;
               size_d = axi_slv.aw_size;
               oor_d = aw_oor;
               beat_d = '0;
            end else if (axi_slv.ar_valid && !rst_i) begin
               state_d = ST_READ;
               id_d = axi_slv.ar_id;
               addr_d = axi_slv.ar_addr;
               len_d = axi_slv.ar_len;
               size_d = axi_slv.ar_size;
               oor_d = ar_oor;
               beat_d = '0;
               acc_addr = axi_slv.ar_addr;
               ram_en = 1'b1;
            end
         end
         ST_WRITE: begin
            axi_slv.w_ready = 1'b1;
            if (axi_slv.w_valid) begin
               ram_en = 1'b1;
               ram_we = ~oor_q;
               addr_d = addr_nxt;
               state_d = axi_slv.w_last ? ST_WRESP : ST_WRITE;
            end
         end
         ST_WRESP: begin
            axi_slv.b_valid = 1'b1;
            state_d = axi_slv.b_ready ? ST_IDLE : ST_WRESP;
         end
         ST_READ: begin
            axi_slv.r_valid = 1'b1;
            if (axi_slv.r_ready) begin
               beat_d = beat_q + 8'd1;
               addr_d = addr_nxt;
               state_d = (beat_q == len_q) ? ST_IDLE : ST_READ;
               acc_addr = addr_nxt;
               ram_en = (beat_q != len_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      state_q <= rst_i ? ST_IDLE : state_d;
   end

   // Burst context, bank mode frozen for the active transaction, bank of the pending read
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_q <= '0;
         addr_q <= '0;
         len_q <= '0;
         size_q <= '0;
         beat_q <= '0;
         oor_q <= 1'b0;
         mode_q <= 1'b0;
         bank_sel_q <= 1'b0;
      end else begin
         id_q <= id_d;
         addr_q <= addr_d;
         len_q <= len_d;
         size_q <= size_d;
         beat_q <= beat_d;
         oor_q <= oor_d;
         mode_q <= mode;
         if (ram_en) bank_sel_q <= ram_bank;
      end
   end

   // phys_in_use register; a single PHY can never enable dual-bank mode
   always_ff @(posedge clk_i) begin
      if (rst_i) phys_in_use_q <= (NumPhys == 2);
      else if (reg_valid_i && reg_write_i && reg_addr_i == RegAw'(RegPhysInUseOff) && reg_wstrb_i[0])
         phys_in_use_q <= reg_wdata_i[0] && (NumPhys == 2);
   end

   for (genvar i = 0; i < NumPhys; i++) begin : g_bank
      hyper_axi_mem_bank #(.DataWidth(AxiDataWidth), .AddrWidth(IdxW - i)) u_bank (
         .clk_i   (clk_i),
         .en_i    (ram_en && ram_bank == 1'(i)),
         .we_i    (ram_we),
         .be_i    (axi_slv.w_strb),
         .addr_i  (ram_idx[IdxW-1-i:0]),
         .wdata_i (axi_slv.w_data),
         .rdata_o (bank_rdata[i])
      );
   end

   assign axi_slv.b_id = id_q;
   assign axi_slv.b_resp = oor_q ? RespSlverr : RespOkay;
   assign axi_slv.b_user = '0;
   assign axi_slv.r_id = id_q;
   assign axi_slv.r_resp = oor_q ? RespSlverr : RespOkay;
   assign axi_slv.r_user = '0;
   assign axi_slv.r_last = (state_q == ST_READ) && (beat_q == len_q);
   assign axi_slv.r_data = oor_q ? '0 : bank_rdata[bank_sel_q];

   assign reg_ready_o = reg_valid_i & ~rst_i;
   assign reg_error_o = 1'b0;
   assign reg_rdata_o = !(reg_valid_i && !reg_write_i && !rst_i) ? '0 :
                        (reg_addr_i == RegAw'(RegIdOff)) ? RegDw'({8'(NumChips), 8'(NumPhys)}) :
                        (reg_addr_i == RegAw'(RegPhysInUseOff)) ? RegDw'(phys_in_use_q) : '0;

   assign unused_ok = ^{axi_slv.aw_burst, axi_slv.ar_burst, axi_slv.aw_user, axi_slv.ar_user,
                        axi_slv.w_user, reg_wdata_i[RegDw-1:1], reg_wstrb_i[RegDw/8-1:1],
                        off_full[AxiAddrWidth-1:OffW], off[Wb-1:0]};
endmodule

// File: tb/tb_hyper_axi_mem_bridge.sv
// tb_hyper_axi_mem_bridge: randomized bursts checked against a byte-addressed window model
module tb_hyper_axi_mem_bridge;
   localparam logic [31:0] Base = 32'h8000_0000;
   localparam int unsigned Bytes = 32'h40_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] reg_addr;
   logic reg_write, reg_valid, reg_error, reg_ready;
   logic [31:0] reg_wdata, reg_rdata, rd;
   logic [3:0] reg_wstrb;
   int checks = 0;
   int failures = 0;
   logic [7:0] model [int unsigned];
   logic [63:0] dq[$];
   logic [7:0] sq[$];

   always #5 clk = ~clk;

   hyper_axi_mem_bridge_if axi ();

   hyper_axi_mem_bridge dut (
      .clk_i(clk), .rst_i(rst), .axi_slv(axi.slave),
      .reg_addr_i(reg_addr), .reg_write_i(reg_write), .reg_wdata_i(reg_wdata),
      .reg_wstrb_i(reg_wstrb), .reg_valid_i(reg_valid), .reg_rdata_o(reg_rdata),
      .reg_error_o(reg_error), .reg_ready_o(reg_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned off_of(input logic [31:0] a);
      return (a - Base) & (Bytes - 1);
   endfunction

   function automatic bit is_oor(input logic [31:0] a);
`ifdef HYPER_AXI_OOR_SLVERR_EN
      return (a < Base) || (a >= Base + Bytes);
`else
      return 1'b0;
`endif
   endfunction

   task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      reg_valid = 1; reg_write = 0; reg_addr = a;
      #1;
      d = reg_rdata;
      check("reg_ready", reg_ready, 1);
      check("reg_error", reg_error, 0);
      reg_valid = 0;
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      reg_valid = 1; reg_write = 1; reg_addr = a; reg_wdata = d; reg_wstrb = s;
      @(posedge clk);
      #1;
      reg_valid = 0; reg_write = 0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [5:0] id,
                            input logic [63:0] data[$], input logic [7:0] strb[$], input bit pre);
      int n;
      bit oor;
      logic [31:0] a;
      oor = is_oor(addr);
      a = addr;
      if (!pre) @(negedge clk);
      axi.aw_addr = addr; axi.aw_len = 8'(len); axi.aw_size = 3'd3; axi.aw_burst = 2'b01;
      axi.aw_id = id; axi.aw_valid = 1;
      n = 0;
      while (!axi.aw_ready && n < 500) begin @(negedge clk); n++; end
      if (!axi.aw_ready) begin check("aw_ready_timeout", axi.aw_ready, 1); axi.aw_valid = 0; return; end
      @(negedge clk);
      axi.aw_valid = 0;
      for (int b = 0; b <= len; b++) begin
         while ($urandom_range(3) == 0) begin axi.w_valid = 0; @(negedge clk); end
         axi.w_valid = 1; axi.w_data = data[b]; axi.w_strb = strb[b]; axi.w_last = (b == len);
         check("w_ready", axi.w_ready, 1);
         if (!axi.w_ready) begin axi.w_valid = 0; return; end
         if (!oor)
            for (int k = 0; k < 8; k++)
               if (strb[b][k]) model[(off_of(a) & ~32'h7) + k] = data[b][8*k +: 8];
         a += 8;
         @(negedge clk);
      end
      axi.w_valid = 0; axi.w_last = 0;
      check("b_latency", axi.b_valid, 1);
      while ($urandom_range(2) == 0) @(negedge clk);
      check("b_hold", axi.b_valid, 1);
      check("b_id", axi.b_id, id);
      check("b_resp", axi.b_resp, oor ? 64'd2 : 64'd0);
      axi.b_ready = 1;
      @(negedge clk);
      axi.b_ready = 0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input logic [5:0] id, input bit pre);
      int n, b;
      bit oor;
      logic [31:0] a;
      logic [63:0] exp, mask;
      oor = is_oor(addr);
      a = addr;
      b = 0;
      if (!pre) @(negedge clk);
      axi.ar_addr = addr; axi.ar_len = 8'(len); axi.ar_size = 3'd3; axi.ar_burst = 2'b01;
      axi.ar_id = id; axi.ar_valid = 1;
      n = 0;
      while (!axi.ar_ready && n < 1000) begin @(negedge clk); n++; end
      if (!axi.ar_ready) begin check("ar_ready_timeout", axi.ar_ready, 1); axi.ar_valid = 0; return; end
      @(negedge clk);
      axi.ar_valid = 0;
      check("r_first_latency", axi.r_valid, 1);
      n = 0;
      while (b <= len && n < 3000) begin
         axi.r_ready = ($urandom_range(3) != 0);
         if (axi.r_valid && axi.r_ready) begin
            exp = '0; mask = '0;
            for (int k = 0; k < 8; k++) begin
               if (oor) mask[8*k +: 8] = 8'hff;
               else if (model.exists((off_of(a) & ~32'h7) + k)) begin
                  mask[8*k +: 8] = 8'hff;
                  exp[8*k +: 8] = model[(off_of(a) & ~32'h7) + k];
               end
            end
            if (mask != 0) check("r_data", axi.r_data & mask, exp);
            check("r_last", axi.r_last, b == len);
            check("r_id", axi.r_id, id);
            check("r_resp", axi.r_resp, oor ? 64'd2 : 64'd0);
            a += 8;
            b++;
         end
         @(negedge clk);
         n++;
      end
      axi.r_ready = 0;
      if (b <= len) check("r_beats_timeout", b, len + 1);
      else check("r_valid_after", axi.r_valid, 0);
   endtask

   task automatic rnd_traffic(input int cnt);
      logic [31:0] aq[$];
      int lq[$];
      logic [31:0] a;
      int l;
      for (int t = 0; t < cnt; t++) begin
         a = Base + 32'($urandom_range(0, Bytes/8 - 1)) * 8;
         l = $urandom_range(0, 15);
         dq.delete(); sq.delete();
         for (int i = 0; i <= l; i++) begin dq.push_back({$urandom, $urandom}); sq.push_back(8'($urandom)); end
         axi_write(a, l, 6'($urandom), dq, sq, 0);
         aq.push_back(a); lq.push_back(l);
      end
      foreach (aq[i]) axi_read(aq[i], lq[i], 6'($urandom), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      axi.aw_valid = 0; axi.w_valid = 0; axi.b_ready = 0; axi.ar_valid = 0; axi.r_ready = 0;
      axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0; axi.aw_user = 0;
      axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0; axi.ar_user = 0;
      axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.w_user = 0;
      reg_addr = 0; reg_write = 0; reg_wdata = 0; reg_wstrb = 0; reg_valid = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reg_valid = 1; reg_addr = 8'h20;
      #1;
      check("rst_aw_ready", axi.aw_ready, 0);
      check("rst_ar_ready", axi.ar_ready, 0);
      check("rst_w_ready", axi.w_ready, 0);
      check("rst_b_valid", axi.b_valid, 0);
      check("rst_r_valid", axi.r_valid, 0);
      check("rst_b_resp", axi.b_resp, 0);
      check("rst_r_resp", axi.r_resp, 0);
      check("rst_reg_ready", reg_ready, 0);
      check("rst_reg_rdata", reg_rdata, 0);
      reg_valid = 0;
      rst = 0;
      reg_rd(8'h20, rd); check("phys_in_use_rst", rd, 1);
      reg_rd(8'h00, rd); check("reg_id", rd, 32'h0202);
      reg_rd(8'h44, rd); check("reg_other", rd, 0);

      dq = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
      sq = '{8'hff, 8'hff, 8'hff, 8'hff};
      axi_write(32'h8000_0100, 3, 6'd5, dq, sq, 0);
      axi_read(32'h8000_0100, 3, 6'd9, 0);

      dq = '{{$urandom, $urandom}};
      sq = '{8'h0f};
      axi_write(32'h8000_0108, 0, 6'd7, dq, sq, 0);
      axi_read(32'h8000_0100, 3, 6'd8, 0);

      @(negedge clk);
      axi.ar_addr = 32'h8000_0100; axi.ar_len = 8'd3; axi.ar_size = 3'd3; axi.ar_id = 6'd3; axi.ar_valid = 1;
      axi.aw_addr = 32'h8000_0200; axi.aw_len = 8'd1; axi.aw_size = 3'd3; axi.aw_id = 6'd4; axi.aw_valid = 1;
      #1;
      check("both_aw_ready", axi.aw_ready, 1);
      check("both_ar_ready", axi.ar_ready, 0);
      dq = '{{$urandom, $urandom}, {$urandom, $urandom}};
      sq = '{8'hff, 8'hff};
      axi_write(32'h8000_0200, 1, 6'd4, dq, sq, 1);
      axi_read(32'h8000_0100, 3, 6'd3, 1);
      axi_read(32'h8000_0200, 1, 6'd2, 0);

      @(negedge clk);
      axi.aw_addr = 32'h8000_0300; axi.aw_len = 8'd3; axi.aw_id = 6'd1; axi.aw_valid = 1;
      @(negedge clk);
      axi.aw_valid = 0; axi.w_valid = 1; axi.w_strb = 8'h00; axi.w_last = 0;
      @(negedge clk);
      axi.w_valid = 0; rst = 1;
      repeat (2) @(negedge clk);
      check("abort_b_valid", axi.b_valid, 0);
      check("abort_w_ready", axi.w_ready, 0);
      rst = 0;
      @(negedge clk);
      check("abort_idle", axi.aw_ready, 1);

      reg_wr(8'h20, 32'h0, 4'h0);
      reg_rd(8'h20, rd); check("wstrb0_ignored", rd, 1);
      reg_wr(8'h20, 32'h0, 4'h1);
      reg_rd(8'h20, rd); check("phys_in_use_0", rd, 0);
      model.delete();
      dq.delete(); sq.delete();
      for (int i = 0; i < 200; i++) begin dq.push_back({$urandom, $urandom}); sq.push_back(8'hff); end
      axi_write(32'h8000_1000, 199, 6'd11, dq, sq, 0);
      axi_read(32'h8000_1000, 199, 6'd12, 0);
      rnd_traffic(8);

      reg_wr(8'h20, 32'h1, 4'h1);
      reg_rd(8'h20, rd); check("phys_in_use_1", rd, 1);
      model.delete();
      rnd_traffic(8);

      dq = '{{$urandom, $urandom}, {$urandom, $urandom}};
      sq = '{8'hff, 8'hff};
      axi_write(32'h7fff_fff8, 1, 6'd13, dq, sq, 0);
      axi_read(32'h7fff_fff8, 1, 6'd14, 0);
      axi_read(32'h8000_0000, 0, 6'd15, 0);
      axi_read(32'h803f_fff8, 0, 6'd16, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
